// File: rtl/idu_inst_queue.sv
// Decode-side in-order instruction queue with combinational RV32I field/immediate extraction.
// Optional build macro IDU_ILLEGAL_CHECK_EN adds the out_illegal flag on the head entry.
module idu_inst_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_pc,
  input  logic [31:0]                   in_inst,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_pc,
  output logic [31:0]                   out_inst,
  output logic [6:0]                    out_opcode,
  output logic [4:0]                    out_rd,
  output logic [4:0]                    out_rs1,
  output logic [4:0]                    out_rs2,
  output logic [2:0]                    out_funct3,
  output logic [6:0]                    out_funct7,
  output logic [DATA_WIDTH-1:0]         out_imm,
`ifdef IDU_ILLEGAL_CHECK_EN
  output logic                          out_illegal,
`endif
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [31:0]           inst_mem_q [DEPTH];

  logic                  push, pop;
  logic [31:0]           imm32;

  // Ready depends only on registered state so fetch never sees a combinational path from execute.
  assign in_ready  = !rst && (count_q < CntW'(DEPTH));
  assign out_valid = !rst && (count_q != '0);
  assign count     = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]   <= in_pc;
      inst_mem_q[wptr_q] <= in_inst;
    end
  end

  assign out_pc   = out_valid ? pc_mem_q[rptr_q]   : '0;
  assign out_inst = out_valid ? inst_mem_q[rptr_q] : NopInst;

  assign out_opcode = out_inst[6:0];
  assign out_rd     = out_inst[11:7];
  assign out_funct3 = out_inst[14:12];
  assign out_rs1    = out_inst[19:15];
  assign out_rs2    = out_inst[24:20];
  assign out_funct7 = out_inst[31:25];

  always_comb begin
    imm32 = 32'h0;
    case (out_opcode)
      OpImm, OpLoad, OpJalr, OpSystem:
        imm32 = {{20{out_inst[31]}}, out_inst[31:20]};
      OpStore:
        imm32 = {{20{out_inst[31]}}, out_inst[31:25], out_inst[11:7]};
      OpBranch:
        imm32 = {{19{out_inst[31]}}, out_inst[31], out_inst[7], out_inst[30:25],
                 out_inst[11:8], 1'b0};
      OpLui, OpAuipc:
        imm32 = {out_inst[31:12], 12'h000};
      OpJal:
        imm32 = {{11{out_inst[31]}}, out_inst[31], out_inst[19:12], out_inst[20],
                 out_inst[30:21], 1'b0};
      default:
        imm32 = 32'h0;
    endcase
  end

  assign out_imm = DATA_WIDTH'(signed'(imm32));

`ifdef IDU_ILLEGAL_CHECK_EN
  logic opcode_known;

  always_comb begin
    opcode_known = 1'b0;
    case (out_opcode)
      OpLoad, OpFence, OpImm, OpAuipc, OpStore, OpReg, OpLui,
      OpBranch, OpJalr, OpJal, OpSystem: opcode_known = 1'b1;
      default:                           opcode_known = 1'b0;
    endcase
  end

  // Flagged entries still pop normally; execute decides what to do with them.
  assign out_illegal = out_valid && ((out_inst[1:0] != 2'b11) || !opcode_known);
`endif

endmodule

// File: tb/tb_idu_inst_queue.sv
// Bench for idu_inst_queue: scoreboard queue model plus a table of decode/immediate vectors.
// Honours IDU_ILLEGAL_CHECK_EN when the DUT is built with it.
module tb_idu_inst_queue;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 2;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [31:0]           in_inst;
  logic                  flush;
  logic                  out_valid, out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [31:0]           out_inst;
  logic [6:0]            out_opcode, out_funct7;
  logic [4:0]            out_rd, out_rs1, out_rs2;
  logic [2:0]            out_funct3;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [CW-1:0]         count;
`ifdef IDU_ILLEGAL_CHECK_EN
  logic                  out_illegal;
`endif

  always #5 clk = ~clk;

  idu_inst_queue #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_funct3 (out_funct3),
    .out_funct7 (out_funct7),
    .out_imm    (out_imm),
`ifdef IDU_ILLEGAL_CHECK_EN
    .out_illegal(out_illegal),
`endif
    .count      (count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic        ill;
  } dec_vec_t;

  entry_t   sb[$];
  dec_vec_t tbl[10];
  int       n_vec = 0;
  int       n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle, compare against the model before the edge, then advance the model.
  task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy, input logic fl);
    logic   do_push, do_pop;
    entry_t e;
    rst = r; in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    #1;
    if (r) begin
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      chk("out_valid_in_reset", 32'(out_valid), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("count", 32'(count), 32'(sb.size()));
      if (sb.size() != 0) begin
        chk("out_pc", out_pc, sb[0].pc);
        chk("out_inst", out_inst, sb[0].inst);
      end else begin
        chk("empty_pc", out_pc, 32'h0);
        chk("empty_inst", out_inst, 32'h0000_0013);
        chk("empty_opcode", 32'(out_opcode), 32'h13);
        chk("empty_imm", out_imm, 32'h0);
      end
    end
    do_push = !r && !fl && v && (sb.size() < DEPTH);
    do_pop  = !r && !fl && ordy && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (r || fl) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.pc = pc; e.inst = inst;
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_fields(input logic [31:0] inst, input logic [31:0] imm,
                              input logic ill);
    chk("opcode", 32'(out_opcode), 32'(inst[6:0]));
    chk("rd", 32'(out_rd), 32'(inst[11:7]));
    chk("rs1", 32'(out_rs1), 32'(inst[19:15]));
    chk("rs2", 32'(out_rs2), 32'(inst[24:20]));
    chk("funct3", 32'(out_funct3), 32'(inst[14:12]));
    chk("funct7", 32'(out_funct7), 32'(inst[31:25]));
    chk("imm", out_imm, imm);
`ifdef IDU_ILLEGAL_CHECK_EN
    chk("illegal", 32'(out_illegal), 32'(ill));
`else
    if (ill === 1'bx) chk("illegal_vec", 32'(ill), 32'd0);
`endif
  endtask

  initial begin
    tbl[0] = '{inst: 32'h0050_0093, imm: 32'h0000_0005, ill: 1'b0};  // addi x1,x0,5
    tbl[1] = '{inst: 32'hFE00_0EE3, imm: 32'hFFFF_FFFC, ill: 1'b0};  // beq -4
    tbl[2] = '{inst: 32'h8000_00EF, imm: 32'hFFF0_0000, ill: 1'b0};  // jal
    tbl[3] = '{inst: 32'h1234_5037, imm: 32'h1234_5000, ill: 1'b0};  // lui
    tbl[4] = '{inst: 32'hFE51_2C23, imm: 32'hFFFF_FFF8, ill: 1'b0};  // sw x5,-8(x2)
    tbl[5] = '{inst: 32'hFFF2_2183, imm: 32'hFFFF_FFFF, ill: 1'b0};  // lw x3,-1(x4)
    tbl[6] = '{inst: 32'h0020_81B3, imm: 32'h0000_0000, ill: 1'b0};  // add x3,x1,x2
    tbl[7] = '{inst: 32'h0000_1097, imm: 32'h0000_1000, ill: 1'b0};  // auipc x1,1
    tbl[8] = '{inst: 32'h0000_0000, imm: 32'h0000_0000, ill: 1'b1};  // all-zero word
    tbl[9] = '{inst: 32'h0080_006F, imm: 32'h0000_0008, ill: 1'b0};  // jal x0,8

    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Reset held for two cycles, then idle.
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Single push, fields visible next cycle, then pop.
    cycle(1'b0, 1'b1, 32'h8000_0000, 32'h0050_0093, 1'b0, 1'b0);
    chk("single_rd", 32'(out_rd), 32'd1);
    chk("single_rs1", 32'(out_rs1), 32'd0);
    chk("single_imm", out_imm, 32'd5);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Back-pressure: third word held while full, then full-with-pop and streaming.
    cycle(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0008, 32'h0020_0093, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd2);
    cycle(1'b0, 1'b1, 32'h8000_0008, 32'h0020_0093, 1'b1, 1'b0);
    chk("pop_only_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b1, 32'h8000_0008, 32'h0020_0093, 1'b1, 1'b0);
    chk("stream_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a concurrent push discards everything.
    cycle(1'b0, 1'b1, 32'h8000_0010, 32'h0030_0093, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0014, 32'h0040_0093, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEC, 32'h0050_0093, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b1, 32'h8000_0100, 32'h0060_0093, 1'b0, 1'b0);
    chk("post_flush_pc", out_pc, 32'h8000_0100);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full-rate streaming across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 32'h8000_0200 + 32'(i * 4), 32'h0000_0093 | 32'(i << 20), 1'b1, 1'b0);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Decode and immediate table.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 32'h8000_0400 + 32'(i * 4), tbl[i].inst, 1'b0, 1'b0);
      check_fields(tbl[i].inst, tbl[i].imm, tbl[i].ill);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
            32'h9000_0000 + 32'(i * 4), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
